// File: rtl/locking_round_robin_arbiter_if.sv
// Request/grant bundle between requesters (master) and the locking round-robin
// arbiter (slave).
interface locking_round_robin_arbiter_if #(
   parameter int width       = 4,
   parameter int index_width = 2
);
   logic [width-1:0]       i_request;
   logic [width-1:0]       o_grant;
   logic                   o_busy;
   logic [index_width-1:0] o_owner;
   logic                   o_timeout;

   modport master (
      output i_request,
      input  o_grant,
      input  o_busy,
      input  o_owner,
      input  o_timeout
   );

   modport slave (
      input  i_request,
      output o_grant,
      output o_busy,
      output o_owner,
      output o_timeout
   );
endinterface

// File: rtl/locking_round_robin_arbiter.sv
// Round-robin arbiter whose grant stays locked to the owner until it releases
// its request or the hold timeout forces a one-cycle release gap.
module locking_round_robin_arbiter #(
   parameter int width          = 4,
   parameter int index_width    = 2,
   parameter int timeout_cycles = 16,
   parameter int timeout_width  = 8
) (
   input logic                           clk,
   input logic                           rst_x,
   locking_round_robin_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_OWNED  = 2'd1,
      S_FORCED = 2'd2
   } state_t;

   // With the timeout disabled this wraps to all-ones, so the counter saturates there.
   localparam logic [timeout_width-1:0] lp_limit     = timeout_width'(timeout_cycles - 1);
   localparam bit                       lp_timeoutOn = (timeout_cycles != 0);

   state_t                   r_state;
   logic [width-1:0]         r_grant;
   logic                     r_busy;
   logic [index_width-1:0]   r_owner;
   logic [timeout_width-1:0] r_count;
   logic                     r_timeout;

   logic                     w_anyRequest;
   logic                     w_ownerHolds;
   logic [index_width-1:0]   w_winner;
   logic [width-1:0]         w_winnerOneHot;
   int                       w_idx;

   // r_owner doubles as the priority pointer: both always hold the last winner.
   always_comb begin
      w_anyRequest = |bus.i_request;
      w_winner     = r_owner;
      w_idx        = 0;
      for (int i = width; i >= 1; i--) begin
         w_idx = (int'(r_owner) + i) % width;
         if (bus.i_request[w_idx[index_width-1:0]]) begin
            w_winner = w_idx[index_width-1:0];
         end
      end
      w_winnerOneHot = width'(1) << w_winner;
      w_ownerHolds   = (r_state == S_OWNED) && bus.i_request[r_owner];
   end

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         r_state   <= S_IDLE;
         r_grant   <= '0;
         r_busy    <= 1'b0;
         r_owner   <= index_width'(width - 1);
         r_count   <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         if (w_ownerHolds) begin
            if (lp_timeoutOn && (r_count == lp_limit)) begin
               r_state   <= S_FORCED;
               r_grant   <= '0;
               r_busy    <= 1'b0;
               r_count   <= '0;
               r_timeout <= 1'b1;
            end else if (r_count != lp_limit) begin
               r_count <= r_count + 1'b1;
            end
         end else if (w_anyRequest) begin
            // Idle, forced gap and owner release all arbitrate the same way.
            r_state <= S_OWNED;
            r_grant <= w_winnerOneHot;
            r_busy  <= 1'b1;
            r_owner <= w_winner;
            r_count <= '0;
         end else begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_count <= '0;
         end
      end
   end

   assign bus.o_grant   = r_grant;
   assign bus.o_busy    = r_busy;
   assign bus.o_owner   = r_owner;
   assign bus.o_timeout = r_timeout;

   grantOneHot : assert property (@(posedge clk) disable iff (!rst_x) $onehot0(r_grant));
   busyMatches : assert property (@(posedge clk) disable iff (!rst_x) r_busy == (|r_grant));

endmodule

// File: tb/tb_locking_round_robin_arbiter.sv
// Directed scoreboard bench for the locking round-robin arbiter, with
// free-running invariant checks and a short random soak.
module tb_locking_round_robin_arbiter;

   localparam int width          = 4;
   localparam int index_width    = 2;
   localparam int timeout_cycles = 16;
   localparam int timeout_width  = 8;

   typedef struct {
      logic [3:0] grant;
      logic [1:0] owner;
      logic       timeout;
      string      name;
   } expect_t;

   logic       clk = 1'b0;
   logic       rst_x;
   logic [3:0] prevRequest = '0;
   expect_t    expQ[$];
   int         checkCount = 0;
   int         failCount  = 0;

   locking_round_robin_arbiter_if #(.width(width), .index_width(index_width)) bus ();

   locking_round_robin_arbiter #(
      .width          (width),
      .index_width    (index_width),
      .timeout_cycles (timeout_cycles),
      .timeout_width  (timeout_width)
   ) dut (
      .clk   (clk),
      .rst_x (rst_x),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checkCount++;
      if (actual !== required) begin
         failCount++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
      end
   endtask

   task automatic pushExpect(input logic [3:0] grant, input logic [1:0] owner, input logic timeout, input string name);
      expect_t e;
      e.grant   = grant;
      e.owner   = owner;
      e.timeout = timeout;
      e.name    = name;
      expQ.push_back(e);
   endtask

   // Drive one cycle of requests; the expectation applies after the next rising edge.
   task automatic applyStimulus(input logic [3:0] req, input logic [3:0] grant, input logic [1:0] owner,
                                input logic timeout, input string name);
      @(negedge clk);
      #1;
      bus.i_request = req;
      pushExpect(grant, owner, timeout, name);
   endtask

   // Scoreboard monitor: one expectation per observed cycle.
   always @(negedge clk) begin : monitor
      expect_t e;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput({e.name, ".grant"},   32'(bus.o_grant),   32'(e.grant));
         checkOutput({e.name, ".owner"},   32'(bus.o_owner),   32'(e.owner));
         checkOutput({e.name, ".timeout"}, 32'(bus.o_timeout), 32'(e.timeout));
         checkOutput({e.name, ".busy"},    32'(bus.o_busy),    32'(|e.grant));
      end
   end

   always @(posedge clk) prevRequest = bus.i_request;

   // Invariants that must hold on every cycle out of reset.
   always @(negedge clk) begin
      if (rst_x === 1'b1) begin
         checkOutput("inv.onehot", 32'($onehot0(bus.o_grant)), 32'd1);
         checkOutput("inv.busy", 32'(bus.o_busy), 32'(|bus.o_grant));
         checkOutput("inv.grantHasRequest", 32'(bus.o_grant & ~prevRequest), 32'd0);
         if (bus.o_timeout) checkOutput("inv.timeoutGap", 32'(bus.o_grant), 32'd0);
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [3:0] oneHot;
      logic [3:0] req;
      logic [3:0] toggle;

      rst_x         = 1'b0;
      bus.i_request = '0;

      applyStimulus(4'b0000, 4'b0000, 2'd3, 1'b0, "reset");
      @(negedge clk);
      #1 rst_x = 1'b1;
      applyStimulus(4'b0000, 4'b0000, 2'd3, 1'b0, "idle");

      // Grant to 1, then hand off to 3 with no bubble.
      applyStimulus(4'b1010, 4'b0010, 2'd1, 1'b0, "t1.grant");
      applyStimulus(4'b1000, 4'b1000, 2'd3, 1'b0, "t1.handoff");
      applyStimulus(4'b0000, 4'b0000, 2'd3, 1'b0, "t1.idle");

      // Everyone requesting, each owner releases after three granted cycles.
      for (int k = 0; k < 4; k++) begin
         oneHot = 4'b0001 << k;
         req    = (k == 0) ? 4'b1111 : (4'b1111 & ~(4'b0001 << (k - 1)));
         applyStimulus(req, oneHot, 2'(k), 1'b0, "rr.switch");
         repeat (2) applyStimulus(4'b1111, oneHot, 2'(k), 1'b0, "rr.hold");
      end
      applyStimulus(4'b0111, 4'b0001, 2'd0, 1'b0, "rr.wrap");
      applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "rr.idle");

      // Requester 2 overstays with 0 pending: 16 cycles, forced gap, then 0.
      applyStimulus(4'b0101, 4'b0100, 2'd2, 1'b0, "to.start");
      repeat (15) applyStimulus(4'b0101, 4'b0100, 2'd2, 1'b0, "to.hold");
      applyStimulus(4'b0101, 4'b0000, 2'd2, 1'b1, "to.forced");
      applyStimulus(4'b0101, 4'b0001, 2'd0, 1'b0, "to.next");
      applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "to.idle");

      // Lone requester 3 re-granted with period 17.
      for (int p = 0; p < 2; p++) begin
         repeat (16) applyStimulus(4'b1000, 4'b1000, 2'd3, 1'b0, "solo.hold");
         applyStimulus(4'b1000, 4'b0000, 2'd3, 1'b1, "solo.forced");
      end
      applyStimulus(4'b0000, 4'b0000, 2'd3, 1'b0, "solo.idle");

      // Asynchronous reset in the middle of ownership.
      applyStimulus(4'b0100, 4'b0100, 2'd2, 1'b0, "ar.grant");
      applyStimulus(4'b0100, 4'b0100, 2'd2, 1'b0, "ar.hold");
      @(negedge clk);
      #3;
      rst_x         = 1'b0;
      bus.i_request = '0;
      #1;
      checkOutput("ar.asyncGrant", 32'(bus.o_grant), 32'd0);
      checkOutput("ar.asyncBusy",  32'(bus.o_busy),  32'd0);
      checkOutput("ar.asyncOwner", 32'(bus.o_owner), 32'd3);
      @(negedge clk);
      #1;
      rst_x         = 1'b1;
      bus.i_request = 4'b1111;
      pushExpect(4'b0001, 2'd0, 1'b0, "ar.after");
      applyStimulus(4'b0000, 4'b0000, 2'd0, 1'b0, "ar.idle");

      // Random soak; only the invariant checker is active here.
      @(negedge clk);
      req = '0;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         #1;
         toggle = '0;
         for (int b = 0; b < 4; b++) toggle[b] = ($urandom_range(0, 7) == 0);
         req           = req ^ toggle;
         bus.i_request = req;
      end

      @(negedge clk);
      #1 bus.i_request = '0;
      repeat (3) @(negedge clk);
      checkOutput("queue.drained", 32'(expQ.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
